// File: rtl/canvas_renderer.sv
// canvas_renderer: 160x120 canvas framebuffer (4x4 screen pixels per cell) with a command port
// and a fixed 2-clock pixel pipeline. Define CANVAS_CURSOR_OVERLAY_EN to add the cursor overlay.
module canvas_renderer #(
  parameter int          CANVAS_W  = 160,
  parameter int          CANVAS_H  = 120,
  parameter logic [11:0] BG_COLOR  = 12'hFFF,
  parameter int          CURSOR_X0 = 80,
  parameter int          CURSOR_Y0 = 60
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_x,
  input  logic [6:0]  cmd_y,
  input  logic [11:0] cmd_color,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        busy
);

  localparam int          DEPTH     = CANVAS_W * CANVAS_H;
  localparam logic [14:0] LAST_ADDR = 15'(DEPTH - 1);
  localparam logic [7:0]  W_LIM     = 8'(CANVAS_W);
  localparam logic [6:0]  H_LIM     = 7'(CANVAS_H);
  localparam logic [1:0]  OP_PLOT   = 2'b00;
  localparam logic [1:0]  OP_CLEAR  = 2'b01;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t      r_state;
  logic [14:0] r_clr_cnt;
  logic [11:0] r_clear_color;

  logic        w_accept;
  logic        w_cmd_in_range;
  logic [14:0] w_cmd_addr;
  logic        w_we;
  logic [14:0] w_waddr;
  logic [11:0] w_wdata;

  assign w_accept       = cmd_valid && cmd_ready;
  assign w_cmd_in_range = (cmd_x < W_LIM) && (cmd_y < H_LIM);
  // row*160 built from two shifts so no multiplier is needed
  assign w_cmd_addr     = ({8'd0, cmd_y} << 7) + ({8'd0, cmd_y} << 5) + {7'd0, cmd_x};

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_cmd_addr;
    w_wdata = cmd_color;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = r_clear_color;
    end else if (w_accept && (cmd_op == OP_PLOT) && w_cmd_in_range) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_CLEAR;
      r_clr_cnt     <= '0;
      r_clear_color <= BG_COLOR;
      cmd_ready     <= 1'b0;
      busy          <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (cmd_op == OP_CLEAR)) begin
            r_clear_color <= cmd_color;
            r_clr_cnt     <= '0;
            r_state       <= S_CLEAR;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_clr_cnt == LAST_ADDR) begin
            r_state   <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 15'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  logic [7:0]  w_row;
  logic [7:0]  w_col;
  logic [14:0] w_rd_addr;
  logic        w_cursor_hit;
  logic        w_unused;

  assign w_row     = y[9:2];
  assign w_col     = x[9:2];
  assign w_rd_addr = ({7'd0, w_row} << 7) + ({7'd0, w_row} << 5) + {7'd0, w_col};

`ifdef CANVAS_CURSOR_OVERLAY_EN
  localparam logic [1:0] OP_MOVE = 2'b10;

  logic [7:0] r_cursor_x;
  logic [6:0] r_cursor_y;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_cursor_x <= 8'(CURSOR_X0);
      r_cursor_y <= 7'(CURSOR_Y0);
    end else if (w_accept && (cmd_op == OP_MOVE) && w_cmd_in_range) begin
      r_cursor_x <= cmd_x;
      r_cursor_y <= cmd_y;
    end
  end

  assign w_cursor_hit = (w_col == r_cursor_x) && (w_row == {1'b0, r_cursor_y});
  assign w_unused     = ^{x[1:0], y[1:0]};
`else
  assign w_cursor_hit = 1'b0;
  assign w_unused     = ^{x[1:0], y[1:0], 8'(CURSOR_X0), 7'(CURSOR_Y0)};
`endif

  // Stage 1: capture the pixel context on the strobe
  logic        r_tick1;
  logic [14:0] r_rd_addr;
  logic        r_von1;
  logic        r_hit1;
  logic        r_hs1;
  logic        r_vs1;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_tick1   <= 1'b0;
      r_rd_addr <= '0;
      r_von1    <= 1'b0;
      r_hit1    <= 1'b0;
      r_hs1     <= 1'b0;
      r_vs1     <= 1'b0;
    end else begin
      r_tick1 <= p_tick;
      if (p_tick) begin
        r_rd_addr <= w_rd_addr;
        r_von1    <= video_on;
        r_hit1    <= w_cursor_hit;
        r_hs1     <= hsync_in;
        r_vs1     <= vsync_in;
      end
    end
  end

  // Stage 2: synchronous RAM read; a same-clock write to the same cell returns the old word
  logic [11:0] r_mem [0:DEPTH-1];
  logic [11:0] r_rd_data;

  always_ff @(posedge clk_100MHz) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
    if (r_tick1) begin
      r_rd_data <= r_mem[r_rd_addr];
    end
  end

  logic r_tick2;
  logic r_von2;
  logic r_hit2;
  logic r_hs2;
  logic r_vs2;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_tick2 <= 1'b0;
      r_von2  <= 1'b0;
      r_hit2  <= 1'b0;
      r_hs2   <= 1'b0;
      r_vs2   <= 1'b0;
    end else begin
      r_tick2 <= r_tick1;
      if (r_tick1) begin
        r_von2 <= r_von1;
        r_hit2 <= r_hit1;
        r_hs2  <= r_hs1;
        r_vs2  <= r_vs1;
      end
    end
  end

  // Stage 3: colour and syncs leave together and hold until the next strobe
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (r_tick2) begin
      hsync_out <= r_hs2;
      vsync_out <= r_vs2;
      if (!r_von2) begin
        rgb <= 12'h000;
      end else if (r_hit2) begin
        rgb <= ~r_rd_data;
      end else begin
        rgb <= r_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_canvas_renderer.sv
// Self-checking bench for canvas_renderer: canvas model plus a pixel scoreboard queue.
module tb_canvas_renderer;

  logic        clk_100MHz = 1'b0;
  logic        reset_n;
  logic        p_tick;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync_in;
  logic        vsync_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [11:0] cmd_color;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        busy;

  always #5 clk_100MHz = ~clk_100MHz;

  canvas_renderer dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_color  (cmd_color),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .busy       (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [11:0] model_mem [0:19199];
  int          model_cx;
  int          model_cy;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    int          px;
    int          py;
  } exp_t;
  exp_t sb_q[$];

  function automatic void model_fill(input logic [11:0] c);
    for (int i = 0; i < 19200; i++) model_mem[i] = c;
  endfunction

  function automatic logic [11:0] model_pixel(input int px, input int py, input logic von);
    int cc;
    int rr;
    logic [11:0] v;
    if (!von) return 12'h000;
    cc = px / 4;
    rr = py / 4;
    v = model_mem[rr * 160 + cc];
`ifdef CANVAS_CURSOR_OVERLAY_EN
    if (cc == model_cx && rr == model_cy) v = ~v;
`endif
    return v;
  endfunction

  task automatic model_reset();
    model_fill(12'hFFF);
    model_cx = 80;
    model_cy = 60;
  endtask

  // One pixel transaction: strobe, 3 idle clocks with scrambled inputs, check hold then result.
  task automatic drive_pixel(input int px, input int py, input logic von, input logic hs, input logic vs);
    exp_t e;
    logic [11:0] prev_rgb;
    logic prev_hs;
    logic prev_vs;
    x = 10'(px);
    y = 10'(py);
    video_on = von;
    hsync_in = hs;
    vsync_in = vs;
    p_tick = 1'b1;
    e.rgb = model_pixel(px, py, von);
    e.hs = hs;
    e.vs = vs;
    e.px = px;
    e.py = py;
    sb_q.push_back(e);
    prev_rgb = rgb;
    prev_hs = hsync_out;
    prev_vs = vsync_out;
    @(posedge clk_100MHz); #1;
    p_tick = 1'b0;
    x = ~x;
    y = ~y;
    video_on = ~von;
    hsync_in = ~hs;
    vsync_in = ~vs;
    @(posedge clk_100MHz); #1;
    vectors++;
    if ({rgb, hsync_out, vsync_out} !== {prev_rgb, prev_hs, prev_vs}) begin
      miscompares++;
      $display("FAIL early_update (%0d,%0d): got rgb=%h hs=%b vs=%b one clock after strobe, required held %h/%b/%b",
               px, py, rgb, hsync_out, vsync_out, prev_rgb, prev_hs, prev_vs);
    end
    @(posedge clk_100MHz); #1;
    e = sb_q.pop_front();
    vectors++;
    if (rgb !== e.rgb || hsync_out !== e.hs || vsync_out !== e.vs) begin
      miscompares++;
      $display("FAIL pixel (%0d,%0d): got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b",
               e.px, e.py, rgb, hsync_out, vsync_out, e.rgb, e.hs, e.vs);
    end else begin
      $display("pixel (%0d,%0d) rgb=%h hs=%b vs=%b ok", e.px, e.py, rgb, hsync_out, vsync_out);
    end
    @(posedge clk_100MHz); #1;
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 25000) begin
      @(posedge clk_100MHz); #1;
      n++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: cmd_ready=%b after %0d clocks, required 1", tag, cmd_ready, n);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input int cx, input int cy, input logic [11:0] col);
    int n;
    wait_ready("cmd_ready", n);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_x = 8'(cx);
    cmd_y = 7'(cy);
    cmd_color = col;
    @(posedge clk_100MHz); #1;
    cmd_valid = 1'b0;
    vectors++;
    if (op == 2'b01) begin
      model_fill(col);
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL clear_start: ready=%b busy=%b, required ready=0 busy=1", cmd_ready, busy);
      end
    end else begin
      if (op == 2'b00 && cx < 160 && cy < 120) model_mem[cy * 160 + cx] = col;
      if (op == 2'b10 && cx < 160 && cy < 120) begin
        model_cx = cx;
        model_cy = cy;
      end
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL handshake op=%b (%0d,%0d): ready=%b busy=%b, required ready=1 busy=0",
                 op, cx, cy, cmd_ready, busy);
      end
    end
    $display("cmd op=%b x=%0d y=%0d color=%h accepted", op, cx, cy, col);
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (rgb !== 12'h000 || hsync_out !== 1'b0 || vsync_out !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: rgb=%h hs=%b vs=%b ready=%b busy=%b, required 000/0/0/0/1",
               tag, rgb, hsync_out, vsync_out, cmd_ready, busy);
    end
  endtask

  task automatic check_clear_len(input string tag, input int n);
    vectors++;
    if (n !== 19200) begin
      miscompares++;
      $display("FAIL %s_len: cmd_ready low for %0d clocks, required 19200", tag, n);
    end else begin
      $display("%s: cmd_ready low for %0d clocks", tag, n);
    end
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    check_reset_outputs("reset_values");
    model_reset();
    reset_n = 1'b1;
    wait_ready("reset_clear", n);
    check_clear_len("reset_clear", n);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_clear: busy=%b, required 0", busy);
    end
    $display("reset done, model cursor (%0d,%0d)", model_cx, model_cy);
  endtask

  task automatic test_background();
    drive_pixel(0, 0, 1'b1, 1'b0, 1'b0);
    drive_pixel(639, 479, 1'b1, 1'b1, 1'b0);
    drive_pixel(320, 240, 1'b1, 1'b0, 1'b1);
    drive_pixel(323, 243, 1'b1, 1'b0, 1'b0);
    drive_pixel(324, 240, 1'b1, 1'b0, 1'b0);
    drive_pixel(319, 243, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_plot();
    send_cmd(2'b00, 10, 5, 12'h0F0);
    drive_pixel(39, 20, 1'b1, 1'b0, 1'b0);
    drive_pixel(40, 20, 1'b1, 1'b0, 1'b0);
    drive_pixel(43, 23, 1'b1, 1'b0, 1'b0);
    drive_pixel(44, 23, 1'b1, 1'b0, 1'b0);
    drive_pixel(41, 19, 1'b1, 1'b0, 1'b0);
    drive_pixel(42, 24, 1'b1, 1'b0, 1'b0);
    drive_pixel(42, 21, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_out_of_range();
    send_cmd(2'b00, 160, 5, 12'hABC);
    send_cmd(2'b00, 3, 120, 12'hABC);
    drive_pixel(0, 24, 1'b1, 1'b0, 1'b0);
    drive_pixel(12, 476, 1'b1, 1'b0, 1'b0);
    drive_pixel(636, 20, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reserved();
    send_cmd(2'b11, 5, 5, 12'h0F0);
    drive_pixel(20, 20, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_blanking();
    drive_pixel(700, 10, 1'b0, 1'b1, 1'b0);
    drive_pixel(100, 490, 1'b0, 1'b0, 1'b1);
    drive_pixel(40, 20, 1'b0, 1'b1, 1'b1);
    drive_pixel(40, 20, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_cursor();
    send_cmd(2'b00, 0, 0, 12'h123);
    send_cmd(2'b10, 0, 0, 12'h000);
    drive_pixel(0, 0, 1'b1, 1'b0, 1'b0);
    drive_pixel(3, 3, 1'b1, 1'b0, 1'b0);
    drive_pixel(4, 0, 1'b1, 1'b0, 1'b0);
    drive_pixel(320, 240, 1'b1, 1'b0, 1'b0);
    send_cmd(2'b10, 200, 0, 12'h000);
    send_cmd(2'b10, 0, 120, 12'h000);
    drive_pixel(2, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_read_before_write();
    exp_t e;
    x = 10'd120;
    y = 10'd120;
    video_on = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    p_tick = 1'b1;
    e.rgb = model_pixel(120, 120, 1'b1);
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.px = 120;
    e.py = 120;
    sb_q.push_back(e);
    @(posedge clk_100MHz); #1;
    p_tick = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_x = 8'd30;
    cmd_y = 7'd30;
    cmd_color = 12'h5A5;
    @(posedge clk_100MHz); #1;
    cmd_valid = 1'b0;
    model_mem[30 * 160 + 30] = 12'h5A5;
    @(posedge clk_100MHz); #1;
    e = sb_q.pop_front();
    vectors++;
    if (rgb !== e.rgb || hsync_out !== e.hs || vsync_out !== e.vs) begin
      miscompares++;
      $display("FAIL read_before_write: got rgb=%h hs=%b vs=%b, required old rgb=%h hs=%b vs=%b",
               rgb, hsync_out, vsync_out, e.rgb, e.hs, e.vs);
    end else begin
      $display("read_before_write (120,120) rgb=%h ok", rgb);
    end
    @(posedge clk_100MHz); #1;
    drive_pixel(121, 121, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clear_held();
    int n;
    send_cmd(2'b01, 0, 0, 12'h00F);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_x = 8'd2;
    cmd_y = 7'd2;
    cmd_color = 12'hF00;
    wait_ready("clear_cmd", n);
    check_clear_len("clear_cmd", n);
    @(posedge clk_100MHz); #1;
    cmd_valid = 1'b0;
    model_mem[2 * 160 + 2] = 12'hF00;
    $display("held plot accepted after clear");
    drive_pixel(0, 0, 1'b1, 1'b0, 1'b0);
    drive_pixel(8, 8, 1'b1, 1'b0, 1'b0);
    drive_pixel(12, 8, 1'b1, 1'b0, 1'b0);
    drive_pixel(639, 479, 1'b1, 1'b0, 1'b0);
    drive_pixel(320, 240, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_clear();
    int n;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    repeat (5000) @(posedge clk_100MHz);
    #1;
    vectors++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear_busy: busy=%b ready=%b, required busy=1 ready=0", busy, cmd_ready);
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk_100MHz);
    #1;
    model_reset();
    reset_n = 1'b1;
    wait_ready("restart_clear", n);
    check_clear_len("restart_clear", n);
    drive_pixel(0, 0, 1'b1, 1'b0, 1'b0);
    drive_pixel(8, 8, 1'b1, 1'b0, 1'b0);
    drive_pixel(639, 479, 1'b1, 1'b0, 1'b0);
    drive_pixel(321, 242, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    p_tick = 1'b0;
    video_on = 1'b0;
    x = '0;
    y = '0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_x = '0;
    cmd_y = '0;
    cmd_color = '0;
    model_cx = 0;
    model_cy = 0;
    test_reset();
    test_background();
    test_plot();
    test_out_of_range();
    test_reserved();
    test_blanking();
    test_cursor();
    test_read_before_write();
    test_clear_held();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
